// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: host write port and baud-timer handshake of the UART transmit controller
interface uart_tx_ctrl_if;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_busy;
  logic       tx_ovf_err;
  logic       tx_err_clr;
  logic       uart_tm_en;
  logic       uart_tm_ov;
  logic       uart_txd;
  modport master (
    output tx_wr, tx_data, tx_err_clr, uart_tm_ov,
    input  tx_full, tx_empty, tx_busy, tx_ovf_err, uart_tm_en, uart_txd
  );
  modport slave (
    input  tx_wr, tx_data, tx_err_clr, uart_tm_ov,
    output tx_full, tx_empty, tx_busy, tx_ovf_err, uart_tm_en, uart_txd
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: FIFO-buffered UART transmitter stepping one bit per baud-timer overflow
module uart_tx_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input logic            clk,
  input logic            rst_x,
  uart_tx_ctrl_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic SC_LAST = 1'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt, cnt_n;
  logic        full, empty, ovf, wr_ok, pop;
  logic [7:0]  rd_data;
  state_t      state, state_n;
  logic [7:0]  sh, sh_n;
  logic [2:0]  bc, bc_n;
  logic        sc, sc_n, txd, txd_n, en, en_n, par, par_n;
  assign wr_ok   = bus.tx_wr & ~full;
  assign rd_data = mem[rd_ptr];
  assign cnt_n   = cnt + (AW+1)'(wr_ok) - (AW+1)'(pop);
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= bus.tx_data;
  always_ff @(posedge clk or negedge rst_x)
    if (!rst_x) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_ok);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt    <= cnt_n;
      full   <= cnt_n == (AW+1)'(FIFO_DEPTH);
      empty  <= cnt_n == '0;
      ovf    <= (bus.tx_wr & full) ? 1'b1 : bus.tx_err_clr ? 1'b0 : ovf;
    end
  always_ff @(posedge clk or negedge rst_x)
    if (!rst_x) begin
      state <= IDLE;
      sh    <= '0;
      bc    <= '0;
      sc    <= 1'b0;
      txd   <= 1'b1;
      en    <= 1'b0;
      par   <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      bc    <= bc_n;
      sc    <= sc_n;
      txd   <= txd_n;
      en    <= en_n;
      par   <= par_n;
    end
  // Loading a new byte is shared by IDLE and the final stop bit so frames chain without a gap
  always_comb begin
    state_n = state;
    sh_n    = sh;
    bc_n    = bc;
    sc_n    = sc;
    txd_n   = txd;
    en_n    = en;
    par_n   = par;
    pop     = 1'b0;
    case (state)
      IDLE:  pop = ~empty;
      START: if (bus.uart_tm_ov) begin
        txd_n   = sh[0];
        sh_n    = sh >> 1;
        bc_n    = '0;
        state_n = DATA;
      end
      DATA: if (bus.uart_tm_ov) begin
        if (bc != 3'd7) begin
          txd_n = sh[0];
          sh_n  = sh >> 1;
          bc_n  = bc + 3'd1;
        end else begin
          txd_n   = (PARITY_EN != 0) ? par : 1'b1;
          sc_n    = 1'b0;
          state_n = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: if (bus.uart_tm_ov) begin
        txd_n   = 1'b1;
        sc_n    = 1'b0;
        state_n = STOP;
      end
      STOP: if (bus.uart_tm_ov) begin
        if (sc != SC_LAST) sc_n = 1'b1;
        else if (empty) begin
          en_n    = 1'b0;
          state_n = IDLE;
        end else pop = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (pop) begin
      sh_n    = rd_data;
      par_n   = ^rd_data ^ 1'(PARITY_ODD);
      txd_n   = 1'b0;
      en_n    = 1'b1;
      state_n = START;
    end
  end
  assign bus.tx_full    = full;
  assign bus.tx_empty   = empty;
  assign bus.tx_busy    = state != IDLE;
  assign bus.tx_ovf_err = ovf;
  assign bus.uart_tm_en = en;
  assign bus.uart_txd   = txd;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed checks of uart_tx_ctrl against a 175-clk baud timer model
module tb_uart_tx_ctrl;
  logic clk = 1'b0;
  logic rst_x = 1'b0;
  logic inj_a = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] ca, cb;
  uart_tx_ctrl_if a ();
  uart_tx_ctrl_if b ();
  uart_tx_ctrl u_a (.clk(clk), .rst_x(rst_x), .bus(a));
  uart_tx_ctrl #(.FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_b (.clk(clk), .rst_x(rst_x), .bus(b));
  always #5 clk = ~clk;
  // Timer model: counts while enabled, overflow pulse every 175 clk, self-clears
  assign a.uart_tm_ov = (a.uart_tm_en && ca == 8'd174) | inj_a;
  assign b.uart_tm_ov = b.uart_tm_en && cb == 8'd174;
  always_ff @(posedge clk or negedge rst_x)
    if (!rst_x) begin
      ca <= '0;
      cb <= '0;
    end else begin
      ca <= (a.uart_tm_en && ca != 8'd174) ? ca + 8'd1 : 8'd0;
      cb <= (b.uart_tm_en && cb != 8'd174) ? cb + 8'd1 : 8'd0;
    end
  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  function automatic logic txd_of(input bit s);
    return s ? b.uart_txd : a.uart_txd;
  endfunction
  function automatic logic en_of(input bit s);
    return s ? b.uart_tm_en : a.uart_tm_en;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input bit s, input logic [7:0] d);
    if (s) begin b.tx_wr = 1'b1; b.tx_data = d; end
    else   begin a.tx_wr = 1'b1; a.tx_data = d; end
    tick(1);
    a.tx_wr = 1'b0;
    b.tx_wr = 1'b0;
  endtask
  task automatic check_frame(input bit s, input logic [11:0] f, input int n, input int start_cyc);
    for (int i = 0; i < n; i++) begin
      automatic int c0 = (i == 0) ? start_cyc : 0;
      chk($sformatf("txd_head[%0d]", i), txd_of(s), f[i]);
      chk($sformatf("tm_en[%0d]", i), en_of(s), 1'b1);
      tick(174 - c0);
      chk($sformatf("txd_tail[%0d]", i), txd_of(s), f[i]);
      tick(1);
    end
  endtask
  task automatic check_idle(input string tag);
    chk({tag, "_txd"}, a.uart_txd, 1'b1);
    chk({tag, "_en"}, a.uart_tm_en, 1'b0);
    chk({tag, "_busy"}, a.tx_busy, 1'b0);
    chk({tag, "_empty"}, a.tx_empty, 1'b1);
  endtask
  initial begin
    logic bad;
    a.tx_wr = 1'b0; a.tx_data = '0; a.tx_err_clr = 1'b0;
    b.tx_wr = 1'b0; b.tx_data = '0; b.tx_err_clr = 1'b0;
    tick(3);
    check_idle("rst");
    chk("rst_full", a.tx_full, 1'b0);
    chk("rst_ovf", a.tx_ovf_err, 1'b0);
    rst_x = 1'b1;
    tick(2);
    wr(0, 8'h55);
    chk("lat_txd_high", a.uart_txd, 1'b1);
    chk("lat_nempty", a.tx_empty, 1'b0);
    tick(1);
    check_frame(0, {1'b1, 8'h55, 1'b0}, 10, 0);
    check_idle("after55");
    tick(5);
    wr(0, 8'hA5);
    chk("b2b_nempty", a.tx_empty, 1'b0);
    wr(0, 8'h3C);
    chk("b2b_nempty2", a.tx_empty, 1'b0);
    check_frame(0, {1'b1, 8'hA5, 1'b0}, 10, 0);
    check_frame(0, {1'b1, 8'h3C, 1'b0}, 10, 0);
    check_idle("afterb2b");
    wr(1, 8'hA5);
    tick(1);
    check_frame(1, {2'b11, 1'b0, 8'hA5, 1'b0}, 12, 0);
    chk("par_idle_en", b.uart_tm_en, 1'b0);
    chk("par_idle_busy", b.tx_busy, 1'b0);
    wr(1, 8'h07);
    tick(1);
    check_frame(1, {2'b11, 1'b1, 8'h07, 1'b0}, 12, 0);
    chk("par_idle_en2", b.uart_tm_en, 1'b0);
    chk("par_idle_txd2", b.uart_txd, 1'b1);
    wr(0, 8'h11);
    wr(0, 8'h22);
    wr(0, 8'h33);
    wr(0, 8'h44);
    chk("not_full3", a.tx_full, 1'b0);
    wr(0, 8'h5A);
    chk("full", a.tx_full, 1'b1);
    chk("ovf_before", a.tx_ovf_err, 1'b0);
    wr(0, 8'hFF);
    chk("ovf_set", a.tx_ovf_err, 1'b1);
    chk("full_hold", a.tx_full, 1'b1);
    a.tx_err_clr = 1'b1;
    tick(1);
    a.tx_err_clr = 1'b0;
    chk("ovf_clr", a.tx_ovf_err, 1'b0);
    a.tx_err_clr = 1'b1;
    wr(0, 8'hEE);
    a.tx_err_clr = 1'b0;
    chk("ovf_set_prio", a.tx_ovf_err, 1'b1);
    check_frame(0, {1'b1, 8'h11, 1'b0}, 10, 6);
    chk("full_drop", a.tx_full, 1'b0);
    check_frame(0, {1'b1, 8'h22, 1'b0}, 10, 0);
    check_frame(0, {1'b1, 8'h33, 1'b0}, 10, 0);
    check_frame(0, {1'b1, 8'h44, 1'b0}, 10, 0);
    check_frame(0, {1'b1, 8'h5A, 1'b0}, 10, 0);
    check_idle("afterfill");
    bad = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (a.uart_txd !== 1'b1 || a.tx_busy !== 1'b0) bad = 1'b1;
    end
    chk("no_dropped_tx", bad, 1'b0);
    a.tx_err_clr = 1'b1;
    tick(1);
    a.tx_err_clr = 1'b0;
    wr(0, 8'h81);
    wr(0, 8'h42);
    tick(175 * 3 + 40);
    chk("pre_rst_busy", a.tx_busy, 1'b1);
    rst_x = 1'b0;
    #1;
    check_idle("async_rst");
    tick(3);
    rst_x = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick(1);
      if (a.uart_txd !== 1'b1 || a.tx_busy !== 1'b0 || a.uart_tm_en !== 1'b0) bad = 1'b1;
    end
    chk("no_residual", bad, 1'b0);
    inj_a = 1'b1;
    tick(1);
    inj_a = 1'b0;
    tick(2);
    check_idle("idle_ov");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
